referee_rr: RTL and testbench

Parametrised successor of the transaction-layer referee. It pops words from one source FIFO and pushes each word into one of NUM_CH destination FIFOs.
- Mode 0 distributes words round-robin over the enabled channels that are not almost full.
- Mode 1 routes each word by a destination field carried in the word.
- Unlike the previous generation, it forwards the data word, skips masked or almost-full channels, sustains one pop per cycle, and drains in-flight words cleanly.

---
 rtl/tl_pkg.sv | 19 +
 rtl/rr_pick.sv | 44 ++++
 rtl/referee_rr.sv | 136 +++++++++++++
 tb/tb_referee_rr.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - transaction-layer shared state encodings and mode constants
package tl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_ROUTE = 1;

  // Only IDLE and ACTIVE may start new source reads.
  function automatic logic state_can_pop(input logic [3:0] st);
    return (st == ST_IDLE) || (st == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr_i, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_req_o
);

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  logic           found;
  logic [W-1:0]   idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[wrap_add(ptr_i, k)]) begin
        found = 1'b1;
        idx   = wrap_add(ptr_i, k);
      end
    end
  end

  always_comb begin
    gnt_oh_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh_o[i] = found && (idx == W'(i));
    end
  end

  assign gnt_idx_o = idx;
  assign any_req_o = found;

endmodule

// File: rtl/referee_rr.sv
// rtl/referee_rr.sv - moves words from one source FIFO to NUM_CH destination FIFOs,
// round-robin over eligible channels or routed by a destination field in the word.
module referee_rr
  import tl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int MODE   = MODE_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              src_empty,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_pop,
  input  logic [NUM_CH-1:0] dst_almost_full,
  output logic [NUM_CH-1:0] dst_push,
  output logic [DATA_W-1:0] dst_data,
  output logic [15:0]       words_out,
  output logic              idle
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CH_P2 = 1 << CH_W;

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              s1_vld_q, s1_vld_d;
  logic [NUM_CH-1:0] s1_oh_q, s1_oh_d;
  logic [NUM_CH-1:0] push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       words_q, words_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CH_W-1:0]   gnt_idx;
  logic              any_elig;
  logic              pop;
  logic [CH_W-1:0]   dest;
  logic [CH_P2-1:0]  mask_ext;
  logic [CH_P2-1:0]  route_ext;
  logic [NUM_CH-1:0] route_oh;

  assign eligible = ch_mask & ~dst_almost_full;

  rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_elig)
  );

  // Routed mode waits until every enabled channel can take a word, since the
  // destination is unknown until the data returns a cycle later.
  always_comb begin
    pop = 1'b0;
    if (!reset && state_can_pop(state) && !src_empty) begin
      if (MODE == MODE_ROUTE) begin
        pop = (|ch_mask) && !(|(ch_mask & dst_almost_full));
      end else begin
        pop = any_elig;
      end
    end
  end

  assign dest = src_data[DATA_W-1 -: CH_W];

  // Indices beyond NUM_CH read as masked, so out-of-range words are dropped.
  always_comb begin
    mask_ext             = '0;
    mask_ext[NUM_CH-1:0] = ch_mask;
    route_ext            = '0;
    route_ext[dest]      = mask_ext[dest];
  end

  assign route_oh = route_ext[NUM_CH-1:0];

  always_comb begin
    ptr_d    = ptr_q;
    s1_vld_d = pop;
    s1_oh_d  = gnt_oh;
    push_d   = '0;
    data_d   = data_q;
    words_d  = words_q + 16'(|push_q);

    if (MODE == MODE_RR && pop) begin
      ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    if (s1_vld_q) begin
      push_d = (MODE == MODE_ROUTE) ? route_oh : s1_oh_q;
    end

    if (|push_d) begin
      data_d = src_data;
    end

    if (state == ST_RESET) begin
      ptr_d    = '0;
      s1_vld_d = 1'b0;
      s1_oh_d  = '0;
      push_d   = '0;
      data_d   = '0;
      words_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_oh_q  <= '0;
      push_q   <= '0;
      data_q   <= '0;
      words_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= s1_vld_d;
      s1_oh_q  <= s1_oh_d;
      push_q   <= push_d;
      data_q   <= data_d;
      words_q  <= words_d;
    end
  end

  assign src_pop   = pop;
  assign dst_push  = push_q;
  assign dst_data  = data_q;
  assign words_out = words_q;
  assign idle      = ~pop & ~s1_vld_q & ~(|push_q);

endmodule

// File: tb/tb_referee_rr.sv
// tb/tb_referee_rr.sv - scoreboard bench for referee_rr in round-robin and routed modes
module tb_referee_rr;

  localparam logic [3:0] S_RESET  = 4'b0001;
  localparam logic [3:0] S_INIT   = 4'b0010;
  localparam logic [3:0] S_IDLE   = 4'b0100;
  localparam logic [3:0] S_ACTIVE = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [3:0]  ch_mask;
  logic [3:0]  dst_af;
  logic [11:0] src_data;
  logic [1:0]  src_empty;
  logic [1:0]  src_pop;
  logic [3:0]  dst_push [2];
  logic [11:0] dst_data [2];
  logic [15:0] words_out [2];
  logic [1:0]  idle;

  always #5 clk = ~clk;

  referee_rr #(.NUM_CH(4), .DATA_W(12), .MODE(0)) u_rr (
    .clk(clk), .reset(reset), .state(state), .ch_mask(ch_mask),
    .src_empty(src_empty[0]), .src_data(src_data), .src_pop(src_pop[0]),
    .dst_almost_full(dst_af), .dst_push(dst_push[0]), .dst_data(dst_data[0]),
    .words_out(words_out[0]), .idle(idle[0])
  );

  referee_rr #(.NUM_CH(4), .DATA_W(12), .MODE(1)) u_rt (
    .clk(clk), .reset(reset), .state(state), .ch_mask(ch_mask),
    .src_empty(src_empty[1]), .src_data(src_data), .src_pop(src_pop[1]),
    .dst_almost_full(dst_af), .dst_push(dst_push[1]), .dst_data(dst_data[1]),
    .words_out(words_out[1]), .idle(idle[1])
  );

  typedef struct {
    int          m;
    int          ch;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] src_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          act = 0;
  int          ptr = 0;
  int          n_push [2];
  logic [11:0] last_data [2];
  logic [3:0]  st_prev = S_RESET;
  bit          pend_vld = 1'b0;
  logic [11:0] pend_word;
  int          pend_cyc;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, a, e, cyc);
    end
  endtask

  task automatic push_exp(input int m, input int ch, input logic [11:0] w, input int c);
    exp_q.push_back('{m, ch, w, c});
    n_push[m]++;
  endtask

  task automatic refresh();
    src_empty[0] = !(act == 0 && src_q.size() > 0);
    src_empty[1] = !(act == 1 && src_q.size() > 0);
  endtask

  task automatic load(input logic [11:0] w);
    src_q.push_back(w);
    refresh();
  endtask

  // One clock: predict the pop from the rules, feed the source FIFO model,
  // and queue the expected push for the scoreboard.
  task automatic step();
    logic [3:0]  elig;
    bit          okst;
    bit          ep;
    int          g;
    int          d;
    logic [11:0] w;
    @(negedge clk);
    if (pend_vld) begin
      d = int'(pend_word[11:10]);
      if (ch_mask[d]) push_exp(1, d, pend_word, pend_cyc);
      pend_vld = 1'b0;
    end
    okst = !reset && (state == S_IDLE || state == S_ACTIVE);
    ep   = 1'b0;
    g    = -1;
    w    = '0;
    if (act == 0) begin
      elig = ch_mask & ~dst_af;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && elig[(ptr + k) % 4]) g = (ptr + k) % 4;
      end
      ep = okst && src_q.size() > 0 && g >= 0;
    end else begin
      ep = okst && src_q.size() > 0 && ch_mask != 4'h0 && (ch_mask & dst_af) == 4'h0;
    end
    chk("src_pop", 32'(src_pop[act]), 32'(ep));
    chk("other_pop_quiet", 32'(src_pop[1-act]), 32'd0);
    if (ep) begin
      w = src_q.pop_front();
      if (act == 0) begin
        push_exp(0, g, w, cyc);
        ptr = (g + 1) % 4;
      end else begin
        pend_vld  = 1'b1;
        pend_word = w;
        pend_cyc  = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (ep) src_data = w;
    refresh();
  endtask

  task automatic clear_sync();
    state = S_RESET;
    step();
    ptr       = 0;
    n_push[0] = 0;
    n_push[1] = 0;
    chk("sync_clear_words", 32'(words_out[act]), 32'd0);
    state = S_IDLE;
  endtask

  task automatic settle(input string name);
    for (int i = 0; i < 60 && (src_q.size() > 0 || exp_q.size() > 0 || pend_vld); i++) step();
    repeat (3) step();
    chk({name, "_words"}, 32'(words_out[act]), 32'(n_push[act] & 16'hFFFF));
    chk({name, "_idle"}, 32'(idle[act]), 32'd1);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset || st_prev == S_RESET) begin
      last_data[0] = '0;
      last_data[1] = '0;
    end
    st_prev = state;
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        if (dst_push[m] != 4'h0) begin
          chk("push_onehot", 32'($onehot(dst_push[m])), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_push", 32'(dst_push[m]), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("push_mode", 32'(m), 32'(mon_e.m));
            chk("push_ch", 32'(dst_push[m]), 32'(1 << mon_e.ch));
            chk("push_data", 32'(dst_data[m]), 32'(mon_e.data));
            chk("push_latency", 32'(cyc - mon_e.cyc), 32'd2);
            last_data[m] = mon_e.data;
          end
        end else begin
          chk("data_hold", 32'(dst_data[m]), 32'(last_data[m]));
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc + 2 < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_push actual=none required=ch%0d data=%0h", exp_q[0].ch, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_push[0] = 0;
    n_push[1] = 0;
    last_data[0] = '0;
    last_data[1] = '0;
    reset     = 1'b1;
    state     = S_RESET;
    ch_mask   = 4'h0;
    dst_af    = 4'h0;
    src_data  = '0;
    src_empty = 2'b11;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("rst_src_pop", 32'(src_pop[m]), 32'd0);
      chk("rst_dst_push", 32'(dst_push[m]), 32'd0);
      chk("rst_dst_data", 32'(dst_data[m]), 32'd0);
      chk("rst_words", 32'(words_out[m]), 32'd0);
      chk("rst_idle", 32'(idle[m]), 32'd1);
    end
    step();
    step();
    reset = 1'b0;
    step();

    // Round-robin over all four channels.
    act = 0;
    clear_sync();
    ch_mask = 4'hF;
    dst_af  = 4'h0;
    for (int i = 1; i <= 8; i++) load(12'(i));
    state = S_ACTIVE;
    settle("rr_full");
    chk("rr_full_count", 32'(words_out[0]), 32'd8);

    // Almost-full channel 1 is skipped.
    clear_sync();
    state  = S_ACTIVE;
    dst_af = 4'b0010;
    for (int i = 0; i < 6; i++) load(12'(16 + i));
    settle("rr_af");
    dst_af = 4'h0;

    // No enabled channels, then a single one.
    clear_sync();
    state   = S_ACTIVE;
    ch_mask = 4'h0;
    for (int i = 0; i < 5; i++) load(12'(32 + i));
    repeat (20) step();
    ch_mask = 4'b0100;
    settle("rr_single");

    // Routed mode.
    act = 1;
    refresh();
    clear_sync();
    state   = S_ACTIVE;
    ch_mask = 4'hF;
    load(12'hC01);
    load(12'h402);
    load(12'h003);
    load(12'h804);
    settle("route");
    ch_mask = 4'b1011;
    load(12'h8AA);
    settle("route_drop");
    chk("route_drop_count", 32'(words_out[1]), 32'd4);
    ch_mask = 4'hF;

    // Async reset with words in flight.
    act = 0;
    refresh();
    clear_sync();
    state = S_ACTIVE;
    for (int i = 0; i < 8; i++) load(12'(12'h100 + i));
    repeat (4) step();
    reset = 1'b1;
    #2;
    chk("midrst_push", 32'(dst_push[0]), 32'd0);
    chk("midrst_pop", 32'(src_pop[0]), 32'd0);
    chk("midrst_words", 32'(words_out[0]), 32'd0);
    exp_q.delete();
    src_q.delete();
    pend_vld  = 1'b0;
    ptr       = 0;
    n_push[0] = 0;
    n_push[1] = 0;
    refresh();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) load(12'(12'h200 + i));
    settle("post_rst");

    // ACTIVE to INIT with two words in flight.
    clear_sync();
    state = S_ACTIVE;
    for (int i = 0; i < 6; i++) load(12'(12'h300 + i));
    repeat (3) step();
    state = S_INIT;
    repeat (6) step();
    chk("init_inflight_done", 32'(words_out[0]), 32'd3);
    state = S_ACTIVE;
    settle("init_resume");

    // Randomized phases in both modes.
    for (int blk = 0; blk < 4; blk++) begin
      act = blk % 2;
      refresh();
      clear_sync();
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 3) == 0) ch_mask = 4'($urandom);
        dst_af = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: state = S_ACTIVE;
          6, 7:             state = S_IDLE;
          default:          state = S_INIT;
        endcase
        if (src_q.size() < 3) load(12'($urandom));
        step();
      end
      state   = S_ACTIVE;
      ch_mask = 4'hF;
      dst_af  = 4'h0;
      settle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
